// File: rtl/preamble_detect_pkg.sv
// Shared types and helpers for the preamble detector stages.
package preamble_detect_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLDOFF
  } state_t;

  // Increment v, saturating at the all-ones value of a w-bit field (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] lim;
    lim = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= lim) ? lim : v + 32'd1;
  endfunction

endpackage

// File: rtl/ratio_compare.sv
// Two-stage ratio threshold: registers num<<FRAC_BITS and den*thresh, then registers (num_scaled >= den_scaled).
module ratio_compare #(
  parameter int unsigned MAG_WIDTH    = 28,
  parameter int unsigned THRESH_WIDTH = 16,
  parameter int unsigned FRAC_BITS    = 15,
  parameter int unsigned TAG_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    flush,
  input  logic                    in_valid,
  input  logic [THRESH_WIDTH-1:0] thresh,
  input  logic [MAG_WIDTH-1:0]    num,
  input  logic [MAG_WIDTH-1:0]    den,
  input  logic [TAG_WIDTH-1:0]    tag,
  output logic                    out_valid,
  output logic                    above,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic [MAG_WIDTH-1:0]    out_num
);

  localparam int unsigned AW = MAG_WIDTH + FRAC_BITS;
  localparam int unsigned PW = MAG_WIDTH + THRESH_WIDTH;
  localparam int unsigned CW = (AW > PW) ? AW : PW;

  logic [CW-1:0]        a1, p1;
  logic                 v1;
  logic [TAG_WIDTH-1:0] tag1;
  logic [MAG_WIDTH-1:0] num1;

  always_ff @(posedge clk) begin
    if (flush) begin
      v1        <= 1'b0;
      a1        <= '0;
      p1        <= '0;
      tag1      <= '0;
      num1      <= '0;
      out_valid <= 1'b0;
      above     <= 1'b0;
      out_tag   <= '0;
      out_num   <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        a1   <= CW'(num) << FRAC_BITS;
        p1   <= CW'(den) * CW'(thresh);
        tag1 <= tag;
        num1 <= num;
      end
      out_valid <= v1;
      if (v1) begin
        above   <= (a1 >= p1);
        out_tag <= tag1;
        out_num <= num1;
      end
    end
  end

endmodule

// File: rtl/preamble_peak_detect.sv
// Plateau/peak detector: qualifies runs of above-threshold samples and reports the
// autocorrelation maximum of each run as a buffered valid/ready event.
module preamble_peak_detect
  import preamble_detect_pkg::*;
#(
  parameter int unsigned PMAG_WIDTH   = 28,
  parameter int unsigned THRESH_WIDTH = 16,
  parameter int unsigned FRAC_BITS    = 15,
  parameter int unsigned LEN_WIDTH    = 16,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    enable,
  input  logic [THRESH_WIDTH-1:0] thresh,
  input  logic [LEN_WIDTH-1:0]    min_len,
  input  logic [LEN_WIDTH-1:0]    max_win,
  input  logic [LEN_WIDTH-1:0]    holdoff,
  input  logic                    in_tvalid,
  output logic                    in_tready,
  input  logic [PMAG_WIDTH-1:0]   acorr_mag_tdata,
  input  logic [PMAG_WIDTH-1:0]   pow_mag_tdata,
  output logic                    peak_tvalid,
  input  logic                    peak_tready,
  output logic [CNT_WIDTH-1:0]    peak_idx,
  output logic [PMAG_WIDTH-1:0]   peak_mag,
  output logic [LEN_WIDTH-1:0]    peak_len,
  output logic                    overflow,
  output logic                    busy
);

  logic                  rst, accept;
  logic [CNT_WIDTH-1:0]  idx;
  logic                  s2_valid, s2_above;
  logic [CNT_WIDTH-1:0]  s2_idx;
  logic [PMAG_WIDTH-1:0] s2_mag;

  state_t                state;
  logic [LEN_WIDTH-1:0]  run, hold_cnt;
  logic [PMAG_WIDTH-1:0] max_mag;
  logic [CNT_WIDTH-1:0]  max_idx;

  logic [LEN_WIDTH-1:0]  min_eff, run_inc, rep_len;
  logic [LEN_WIDTH:0]    hold_next;
  logic                  cand_new, rep;
  logic [PMAG_WIDTH-1:0] cand_mag, rep_mag;
  logic [CNT_WIDTH-1:0]  cand_idx, rep_idx;

  assign rst       = reset | clear;
  assign in_tready = ~rst;
  assign accept    = in_tvalid & in_tready;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) idx <= '0;
    else if (accept) idx <= idx + CNT_WIDTH'(1);
  end

  ratio_compare #(
    .MAG_WIDTH    (PMAG_WIDTH),
    .THRESH_WIDTH (THRESH_WIDTH),
    .FRAC_BITS    (FRAC_BITS),
    .TAG_WIDTH    (CNT_WIDTH)
  ) u_ratio (
    .clk       (clk),
    .flush     (rst),
    .in_valid  (accept),
    .thresh    (thresh),
    .num       (acorr_mag_tdata),
    .den       (pow_mag_tdata),
    .tag       (idx),
    .out_valid (s2_valid),
    .above     (s2_above),
    .out_tag   (s2_idx),
    .out_num   (s2_mag)
  );

  // Report decision is shared by the state update and the event buffer below.
  always_comb begin
    min_eff   = (min_len == '0) ? LEN_WIDTH'(1) : min_len;
    run_inc   = LEN_WIDTH'(sat_inc(32'(run), LEN_WIDTH));
    hold_next = {1'b0, hold_cnt} + (LEN_WIDTH+1)'(1);
    cand_new  = (s2_mag > max_mag);
    cand_mag  = cand_new ? s2_mag : max_mag;
    cand_idx  = cand_new ? s2_idx : max_idx;
    rep       = 1'b0;
    rep_idx   = max_idx;
    rep_mag   = max_mag;
    rep_len   = run;
    if (s2_valid && enable) begin
      case (state)
        IDLE: begin
          if (s2_above && min_len <= LEN_WIDTH'(1) && max_win == LEN_WIDTH'(1)) begin
            rep     = 1'b1;
            rep_idx = s2_idx;
            rep_mag = s2_mag;
            rep_len = LEN_WIDTH'(1);
          end
        end
        RUN: begin
          if (s2_above) begin
            if (max_win != '0 && run_inc == max_win) begin
              rep     = 1'b1;
              rep_idx = cand_idx;
              rep_mag = cand_mag;
              rep_len = run_inc;
            end
          end else if (run >= min_eff) begin
            rep = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      run         <= '0;
      hold_cnt    <= '0;
      max_mag     <= '0;
      max_idx     <= '0;
      peak_tvalid <= 1'b0;
      peak_idx    <= '0;
      peak_mag    <= '0;
      peak_len    <= '0;
      overflow    <= 1'b0;
    end else begin
      if (!enable) begin
        state <= IDLE;
      end else if (s2_valid) begin
        case (state)
          IDLE: begin
            if (s2_above) begin
              run      <= LEN_WIDTH'(1);
              max_mag  <= s2_mag;
              max_idx  <= s2_idx;
              hold_cnt <= '0;
              state    <= rep ? HOLDOFF : RUN;
            end
          end
          RUN: begin
            hold_cnt <= '0;
            if (s2_above) begin
              run     <= run_inc;
              max_mag <= cand_mag;
              max_idx <= cand_idx;
              if (rep) state <= HOLDOFF;
            end else begin
              state <= rep ? HOLDOFF : IDLE;
            end
          end
          HOLDOFF: begin
            if (hold_next >= {1'b0, holdoff}) state <= IDLE;
            else hold_cnt <= hold_next[LEN_WIDTH-1:0];
          end
          default: state <= IDLE;
        endcase
      end

      // A pending, unaccepted event is kept; the new one is dropped and flagged.
      if (rep) begin
        if (peak_tvalid && !peak_tready) begin
          overflow <= 1'b1;
        end else begin
          peak_tvalid <= 1'b1;
          peak_idx    <= rep_idx;
          peak_mag    <= rep_mag;
          peak_len    <= rep_len;
        end
      end else if (peak_tvalid && peak_tready) begin
        peak_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_preamble_peak_detect.sv
// Randomized and directed bench for preamble_peak_detect against a sample-level reference model.
module tb_preamble_peak_detect;

  localparam int PW = 28;
  localparam int TW = 16;
  localparam int FB = 15;
  localparam int LW = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset, clear, enable;
  logic [TW-1:0] thresh;
  logic [LW-1:0] min_len, max_win, holdoff;
  logic          in_tvalid, in_tready;
  logic [PW-1:0] acorr, pow;
  logic          peak_tvalid, peak_tready;
  logic [CW-1:0] peak_idx;
  logic [PW-1:0] peak_mag;
  logic [LW-1:0] peak_len;
  logic          overflow, busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  preamble_peak_detect #(
    .PMAG_WIDTH   (PW),
    .THRESH_WIDTH (TW),
    .FRAC_BITS    (FB),
    .LEN_WIDTH    (LW),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .clear           (clear),
    .enable          (enable),
    .thresh          (thresh),
    .min_len         (min_len),
    .max_win         (max_win),
    .holdoff         (holdoff),
    .in_tvalid       (in_tvalid),
    .in_tready       (in_tready),
    .acorr_mag_tdata (acorr),
    .pow_mag_tdata   (pow),
    .peak_tvalid     (peak_tvalid),
    .peak_tready     (peak_tready),
    .peak_idx        (peak_idx),
    .peak_mag        (peak_mag),
    .peak_len        (peak_len),
    .overflow        (overflow),
    .busy            (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: one call per clock edge, evaluating samples two edges after acceptance.
  typedef struct {
    bit v;
    int idx;
    int mag;
    bit above;
  } smp_t;

  smp_t pipe[2];
  int   m_mode, m_run, m_mx, m_mxi, m_hc, m_idx;
  int   m_pidx, m_pmag, m_plen;
  bit   m_pv, m_ovf;

  task automatic model_edge();
    smp_t ev, nw;
    bit   rep;
    int   r_idx, r_mag, r_len, minl;
    if (reset || clear) begin
      m_mode = 0; m_run = 0; m_mx = 0; m_mxi = 0; m_hc = 0; m_idx = 0;
      m_pv = 0; m_pidx = 0; m_pmag = 0; m_plen = 0; m_ovf = 0;
      pipe[0] = '{default: 0};
      pipe[1] = '{default: 0};
      return;
    end
    ev      = pipe[1];
    pipe[1] = pipe[0];
    nw.v     = in_tvalid;
    nw.idx   = m_idx;
    nw.mag   = int'(acorr);
    nw.above = (longint'(acorr) * 64'd32768) >= (longint'(pow) * longint'(thresh));
    pipe[0]  = nw;
    if (in_tvalid) m_idx = (m_idx + 1) % 256;

    rep = 0; r_idx = 0; r_mag = 0; r_len = 0;
    minl = (min_len == 0) ? 1 : int'(min_len);
    if (!enable) begin
      m_mode = 0;
    end else if (ev.v) begin
      if (m_mode == 0) begin
        if (ev.above) begin
          m_run = 1; m_mx = ev.mag; m_mxi = ev.idx; m_mode = 1;
          if (min_len <= 1 && max_win == 1) begin
            rep = 1; r_idx = ev.idx; r_mag = ev.mag; r_len = 1; m_mode = 2; m_hc = 0;
          end
        end
      end else if (m_mode == 1) begin
        if (ev.above) begin
          if (m_run < 65535) m_run++;
          if (ev.mag > m_mx) begin m_mx = ev.mag; m_mxi = ev.idx; end
          if (max_win != 0 && m_run == int'(max_win)) begin
            rep = 1; r_idx = m_mxi; r_mag = m_mx; r_len = m_run; m_mode = 2; m_hc = 0;
          end
        end else if (m_run >= minl) begin
          rep = 1; r_idx = m_mxi; r_mag = m_mx; r_len = m_run; m_mode = 2; m_hc = 0;
        end else begin
          m_mode = 0;
        end
      end else begin
        m_hc++;
        if (m_hc >= int'(holdoff)) m_mode = 0;
      end
    end

    if (rep) begin
      if (m_pv && !peak_tready) m_ovf = 1;
      else begin m_pv = 1; m_pidx = r_idx; m_pmag = r_mag; m_plen = r_len; end
    end else if (m_pv && peak_tready) begin
      m_pv = 0;
    end
  endtask

  task automatic check_outputs();
    check("in_tready",   64'(in_tready),   64'(!(reset || clear)));
    check("peak_tvalid", 64'(peak_tvalid), 64'(m_pv));
    check("peak_idx",    64'(peak_idx),    64'(m_pidx));
    check("peak_mag",    64'(peak_mag),    64'(m_pmag));
    check("peak_len",    64'(peak_len),    64'(m_plen));
    check("overflow",    64'(overflow),    64'(m_ovf));
    check("busy",        64'(busy),        64'(m_mode != 0));
  endtask

  // Drive one cycle of input, advance the model, then check after the edge.
  task automatic step(input bit v, input int a, input int p);
    in_tvalid = v;
    acorr     = PW'(a);
    pow       = PW'(p);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  int plat[6] = '{800, 850, 900, 900, 820, 810};

  initial begin
    bit seen;
    reset = 1; clear = 0; enable = 1; thresh = 16'h6000;
    min_len = 4; max_win = 0; holdoff = 0; peak_tready = 0;
    in_tvalid = 0; acorr = '0; pow = '0;
    repeat (3) step(0, 0, 0);
    check("rst_in_tready", 64'(in_tready), 64'd0);
    check("rst_peak_tvalid", 64'(peak_tvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset = 0;

    // Basic plateau at idx 100..105, terminated by idx 106.
    repeat (100) step(1, 700, 1000);
    foreach (plat[i]) step(1, plat[i], 1000);
    step(1, 700, 1000);
    check("plat_lat0", 64'(peak_tvalid), 64'd0);
    step(0, 0, 0);
    check("plat_lat1", 64'(peak_tvalid), 64'd0);
    step(0, 0, 0);
    check("plat_valid", 64'(peak_tvalid), 64'd1);
    check("plat_idx", 64'(peak_idx), 64'd102);
    check("plat_mag", 64'(peak_mag), 64'd900);
    check("plat_len", 64'(peak_len), 64'd6);
    peak_tready = 1;
    step(0, 0, 0);
    check("plat_drop", 64'(peak_tvalid), 64'd0);

    // Short run rejected.
    repeat (3) step(1, 700, 1000);
    repeat (3) step(1, 800, 1000);
    repeat (4) step(1, 700, 1000);
    check("short_tvalid", 64'(peak_tvalid), 64'd0);
    check("short_busy", 64'(busy), 64'd0);
    check("short_ovf", 64'(overflow), 64'd0);

    // Forced report every 8 samples with holdoff 5.
    max_win = 8; holdoff = 5; seen = 0;
    for (int i = 0; i < 30; i++) begin
      step(1, 800 + i, 1000);
      if (peak_tvalid && !seen) begin
        seen = 1;
        check("forced_len", 64'(peak_len), 64'd8);
      end
    end
    check("forced_seen", 64'(seen), 64'd1);
    max_win = 0;
    repeat (10) step(1, 700, 1000);

    // Overflow: second event dropped while the first is held.
    peak_tready = 0; min_len = 2; holdoff = 2;
    step(1, 800, 1000); step(1, 900, 1000); step(1, 850, 1000);
    repeat (3) step(1, 700, 1000);
    step(1, 810, 1000); step(1, 820, 1000); step(1, 830, 1000);
    repeat (4) step(1, 700, 1000);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_held_valid", 64'(peak_tvalid), 64'd1);
    check("ovf_held_mag", 64'(peak_mag), 64'd900);
    check("ovf_held_len", 64'(peak_len), 64'd3);
    peak_tready = 1;
    step(0, 0, 0);
    check("ovf_drain", 64'(peak_tvalid), 64'd0);
    clear = 1;
    step(0, 0, 0);
    clear = 0;
    check("clear_ovf", 64'(overflow), 64'd0);

    // Index wrap: run over idx 250..259 with the maximum at 258 (reported as 2).
    min_len = 4; holdoff = 0;
    for (int g = 0; g < 300 && m_idx != 250; g++) step(1, 700, 1000);
    peak_tready = 0;
    for (int i = 0; i < 10; i++) step(1, (i == 8) ? 1000 : 800 + i, 1000);
    step(1, 700, 1000);
    step(0, 0, 0); step(0, 0, 0);
    check("wrap_valid", 64'(peak_tvalid), 64'd1);
    check("wrap_idx", 64'(peak_idx), 64'd2);
    check("wrap_mag", 64'(peak_mag), 64'd1000);
    peak_tready = 1;
    step(0, 0, 0);

    // Same plateau with random input gaps.
    repeat (4) step(1, 700, 1000);
    foreach (plat[i]) begin
      for (int g = 0; g < 8 && $urandom_range(1, 0) == 0; g++) step(0, 0, 0);
      step(1, plat[i], 1000);
    end
    peak_tready = 0;
    step(1, 700, 1000);
    seen = 0;
    for (int g = 0; g < 20 && !seen; g++) begin
      step($urandom_range(1, 0) == 1, 700, 1000);
      seen = peak_tvalid;
    end
    check("gap_seen", 64'(seen), 64'd1);
    check("gap_mag", 64'(peak_mag), 64'd900);
    check("gap_len", 64'(peak_len), 64'd6);
    peak_tready = 1;
    repeat (3) step(1, 700, 1000);

    // Reset mid-run with an event pending.
    peak_tready = 0;
    repeat (5) step(1, 800, 1000);
    step(1, 700, 1000); step(0, 0, 0); step(0, 0, 0);
    repeat (3) step(1, 800, 1000);
    reset = 1;
    step(1, 800, 1000);
    check("midrst_tvalid", 64'(peak_tvalid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(in_tready), 64'd0);
    reset = 0;
    repeat (6) step(1, 700, 1000);
    check("midrst_noevt", 64'(peak_tvalid), 64'd0);

    // Enable dropped mid-run discards the run.
    repeat (5) step(1, 800, 1000);
    enable = 0;
    step(1, 800, 1000);
    check("en_busy", 64'(busy), 64'd0);
    enable = 1;
    repeat (6) step(1, 700, 1000);
    check("en_noevt", 64'(peak_tvalid), 64'd0);

    // Randomized traffic with changing settings.
    for (int i = 0; i < 4000; i++) begin
      int p;
      if ($urandom_range(31, 0) == 0) begin
        min_len = LW'($urandom_range(5, 0));
        max_win = ($urandom_range(2, 0) == 0) ? LW'($urandom_range(10, 0)) : '0;
        holdoff = LW'($urandom_range(4, 0));
        case ($urandom_range(2, 0))
          0: thresh = 16'h6000;
          1: thresh = 16'h4000;
          default: thresh = 16'h7000;
        endcase
      end
      peak_tready = ($urandom_range(3, 0) != 0);
      enable      = ($urandom_range(49, 0) != 0);
      clear       = ($urandom_range(199, 0) == 0);
      p = int'($urandom_range(2000, 500));
      step($urandom_range(3, 0) != 0, (p * 3) / 4 + int'($urandom_range(120, 0)) - 60, p);
    end
    clear = 0; enable = 1;
    step(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/preamble_peak_detect.md
# preamble_peak_detect

Runtime-configurable plateau/peak detector that follows the autocorrelation and power-magnitude stages of the preamble detector. It declares a sample above threshold when `acorr_mag * 2^FRAC_BITS >= pow_mag * thresh`. It qualifies a plateau of at least `min_len` samples and locates the autocorrelation maximum inside it. Each detection is reported as one buffered event (index and magnitude) on a valid/ready port, followed by a programmable holdoff.

## Interface
- `PMAG_WIDTH`, 28: width of the unsigned `acorr_mag`/`pow_mag` inputs
- `THRESH_WIDTH`, 16: width of the unsigned threshold ratio
- `FRAC_BITS`, 15: fractional bits of `thresh`; 0x6000 = 0.75
- `LEN_WIDTH`, 16: width of `min_len`, `max_win`, `holdoff` and their counters
- `CNT_WIDTH`, 32: width of the sample index counter

- `clk` in 1: single clock
- `reset` in 1: synchronous, active-high
- `clear` in 1: synchronous, active-high; same effect as `reset`
- `enable` in 1: 0 forces IDLE; index counting continues
- `thresh` in THRESH_WIDTH: threshold ratio
- `min_len` in LEN_WIDTH: minimum plateau length; 0 is treated as 1
- `max_win` in LEN_WIDTH: maximum run length before a forced report; 0 means unlimited
- `holdoff` in LEN_WIDTH: samples ignored after a report
- `in_tvalid` in 1: input sample valid
- `in_tready` out 1: constant 1 outside reset; 0 during reset
- `acorr_mag_tdata` in PMAG_WIDTH: autocorrelation magnitude
- `pow_mag_tdata` in PMAG_WIDTH: power magnitude
- `peak_tvalid` out 1: detection event pending
- `peak_tready` in 1: consumer accepts the event
- `peak_idx` out CNT_WIDTH: sample index of the maximum
- `peak_mag` out PMAG_WIDTH: acorr magnitude at the maximum
- `peak_len` out LEN_WIDTH: run length at report, saturating
- `overflow` out 1: sticky; set when an event is lost
- `busy` out 1: FSM not in IDLE

## Operation
- **Sample acceptance and index.** A sample is accepted on `in_tvalid`. `idx` counts accepted samples, starting at 0 after reset/clear, and wraps modulo 2^CNT_WIDTH.
- **Stage 1 (registered).** Computes `a = acorr_mag << FRAC_BITS` and `p = pow_mag * thresh`, both full-width unsigned with no truncation. It also carries `idx`, `acorr_mag` and valid.
- **Stage 2.** Forms `above = (a >= p)`. The FSM advances only on stage-2 valid.
- **IDLE.**
  - If `above` and `enable`: go to RUN with run=1, max=acorr, max_idx=idx.
  - If additionally min_len≤1 and max_win==1: report immediately, then go to HOLDOFF.
- **RUN**, on each valid stage-2 sample:
  - If `above`: run++ (saturating at all-ones). If acorr > max (strict, so the first maximum wins on ties), update max and max_idx. If max_win≠0 and run==max_win, report and go to HOLDOFF.
  - If not `above`: report if run ≥ max(min_len,1), then go to HOLDOFF; otherwise go to IDLE silently.
- **HOLDOFF.** Counts `holdoff` valid samples, then returns to IDLE. With holdoff=0, return to IDLE on the next valid sample without evaluating that sample. Samples are ignored in this state.
- **Report.** Loads `peak_idx`/`peak_mag`/`peak_len` and sets `peak_tvalid`.
  - If `peak_tvalid` is already high and `peak_tready` is low on the same edge, the new event is dropped, `overflow` is set, and the pending event is retained.
  - If the pending event is accepted on the same edge that a new one is loaded, the new event wins and there is no overflow.
- **enable low.** Forces IDLE on the next edge and discards any run in progress; a pending event is kept.
- **Settings.** `thresh` takes effect on the next accepted sample. `min_len`/`max_win`/`holdoff` are sampled on each FSM evaluation; changing them mid-run is legal and uses the new value.

## Timing
- **Reset/clear values.** All outputs 0, `in_tready`=0, state IDLE, pipeline valids 0, `idx`=0, `overflow` cleared.
- **Latency.** For a sample accepted at edge k, `above` is evaluated at edge k+1. If that sample terminates a run, `peak_tvalid`=1 after edge k+2.
- **Event handshake.** `peak_*` fields are stable while `peak_tvalid`=1 and `peak_tready`=0. Transfer happens when both are high. `peak_tvalid` drops on the next edge unless a new event is loaded on that edge.
- **Reset during RUN or a pending event.** Discards everything on the next edge.

## Structure
- Package `preamble_detect_pkg`: FSM state enum (IDLE, RUN, HOLDOFF) and the saturating-increment helper.
- Natural sub-module: `ratio_compare` (stage-1 products plus stage-2 compare, 2-cycle, valid-carrying). It is reusable by other threshold stages.

## Test plan
Unless stated otherwise: thresh=0x6000 (0.75), pow=1000, "above" acorr=800, "below" acorr=700.

- **Basic plateau.** min_len=4, holdoff=0. Idle input, then 6 above samples at idx 100–105 with acorr values 800,850,900,900,820,810, then below. Expect one event: `peak_idx`=102, `peak_mag`=900, `peak_len`=6, `peak_tvalid` 2 cycles after idx 106 is accepted.
- **Short run rejected.** min_len=4. Three above samples, then below. Expect no event, `busy` back to 0, `overflow`=0.
- **Forced report.** max_win=8 with a continuous above run. Expect an event at run=8. With holdoff=5: the next 5 samples are ignored, then a new run starts at the 6th above sample.
- **Overflow.** `peak_tready`=0, two qualifying runs separated by holdoff=2. Expect the first event held unchanged and `overflow`=1. Then with `peak_tready`=1 for one cycle, `peak_tvalid` drops.
- **Gaps and index wrap.** Toggle `in_tvalid` randomly 50% across a detection. Expect identical event fields to the gap-free run. With CNT_WIDTH=8, start idx at 250 with the peak at idx 258: expect `peak_idx`=2.
- **Reset and enable mid-run.** Assert `reset` mid-run. Expect all outputs 0 the next cycle and no event afterwards. Drop `enable` mid-run: expect IDLE and no event.
